// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// one command byte with odd parity, then check the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 50,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       psClk_in,
  input  logic       psData_in,
  output logic       psClk_oe,
  output logic       psData_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_START,
    SEND,
    ACK,
    WAIT_REL,
    DONE,
    ABORT
  } state_e;

  localparam logic [19:0] TMR_MAX = 20'hFFFFF;

  state_e      state_q, state_d;
  logic [19:0] tmr_q, tmr_d;
  logic [19:0] tmr_inc;
  logic [31:0] tmr_n;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        data_oe_q, data_oe_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        clk_oe_q;
  logic        busy_q;
  logic        tx_ready_q;
  logic        done_q;
  logic        error_q;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic data_s1_q, data_s2_q;
  logic fall;

  // Syncs idle high so reset never fabricates a falling edge.
  always_ff @(posedge Clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= psClk_in;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      data_s1_q <= psData_in;
      data_s2_q <= data_s1_q;
    end
  end

  assign fall    = clk_s3_q & ~clk_s2_q;
  assign tmr_inc = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 20'd1;
  assign tmr_n   = 32'(tmr_q) + 32'd1;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    data_oe_d  = data_oe_q;
    err_code_d = err_code_q;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (tx_valid && tx_ready_q) begin
          shreg_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (tmr_n >= INHIBIT_CYCLES) begin
          tmr_d   = '0;
          state_d = REQ;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      REQ: begin
        if (tmr_n >= REQ_CYCLES) begin
          tmr_d   = '0;
          state_d = WAIT_START;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      WAIT_START: begin
        if (fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bitcnt_d  = 4'd1;
          tmr_d     = '0;
          state_d   = SEND;
        end else if (tmr_n >= START_TIMEOUT) begin
          err_code_d = 2'b01;
          state_d    = ABORT;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      SEND: begin
        if (tmr_n >= XFER_TIMEOUT) begin
          err_code_d = 2'b10;
          state_d    = ABORT;
        end else begin
          tmr_d = tmr_inc;
          if (fall) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bitcnt_d  = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (tmr_n >= XFER_TIMEOUT) begin
          err_code_d = 2'b10;
          state_d    = ABORT;
        end else begin
          tmr_d = tmr_inc;
          if (fall) begin
            if (!data_s2_q) begin
              state_d = WAIT_REL;
            end else begin
              err_code_d = 2'b11;
              state_d    = ABORT;
            end
          end
        end
      end
      WAIT_REL: begin
        if (tmr_n >= XFER_TIMEOUT) begin
          err_code_d = 2'b11;
          state_d    = ABORT;
        end else begin
          tmr_d = tmr_inc;
          if (clk_s2_q && data_s2_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Data line is ours only from the start bit through the stop bit.
    if (state_d inside {IDLE, INHIBIT, WAIT_REL, DONE, ABORT})
      data_oe_d = 1'b0;
    else if (state_d == REQ)
      data_oe_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      data_oe_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      data_oe_q  <= data_oe_d;
      clk_oe_q   <= (state_d == INHIBIT) || (state_d == REQ);
      busy_q     <= (state_d != IDLE);
      tx_ready_q <= (state_d == IDLE);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ABORT);
      err_code_q <= err_code_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign psClk_oe  = clk_oe_q;
  assign psData_oe = data_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed scenarios plus random bytes against
// a frame-level model and a clock-generating PS/2 device model.
module tb_ps2_host_tx;

  logic       Clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       psClk_in, psData_in;
  logic       psClk_oe, psData_oe;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic       dev_clk, dev_data;

  int vectors = 0;
  int miscompares = 0;
  int ndone = 0, nerr = 0, nboth = 0;

  always #5 Clk = ~Clk;

  assign psClk_in  = dev_clk & ~psClk_oe;
  assign psData_in = dev_data & ~psData_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .REQ_CYCLES(4),
    .START_TIMEOUT(2000),
    .XFER_TIMEOUT(4000)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .psClk_in(psClk_in),
    .psData_in(psData_in),
    .psClk_oe(psClk_oe),
    .psData_oe(psData_oe),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  always @(negedge Clk) begin
    if (done) ndone++;
    if (error) nerr++;
    if (done && error) nboth++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line values seen on falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int   ones;
    logic p;
    ones = $countones(b);
    p = ((ones % 2) == 0);
    return {1'b1, p, b};
  endfunction

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic phases(output int inh, output int rq);
    inh = 0;
    rq  = 0;
    while (psClk_oe && !psData_oe && inh < 100) begin
      inh++;
      tick();
    end
    while (psClk_oe && psData_oe && rq < 100) begin
      rq++;
      tick();
    end
  endtask

  // mode 0 ACK, 1 NACK, 2 stall after fall 5, 4 stop after fall 4
  task automatic dev(input int mode, output logic [9:0] seen,
                     output int ok);
    int t;
    t = 0;
    seen = '0;
    ok = 0;
    while (!(!psClk_oe && psData_oe) && t < 200) begin
      t++;
      tick();
    end
    if (t >= 200) return;
    ok = 1;
    tick(10);
    for (int i = 1; i <= 11; i++) begin
      if ((mode == 2 && i == 6) || (mode == 4 && i == 5)) return;
      if (i == 11 && mode == 0) dev_data = 1'b0;
      dev_clk = 1'b0;
      tick(32);
      if (i <= 10) seen[i-1] = psData_in;
      dev_clk = 1'b1;
      tick(32);
    end
    dev_data = 1'b1;
  endtask

  task automatic good_xfer(input string tag, input logic [7:0] b);
    int d0, e0, inh, rq, ok;
    logic [9:0] seen;
    d0 = ndone;
    e0 = nerr;
    send(b);
    phases(inh, rq);
    dev(0, seen, ok);
    check({tag, "_req"}, 32'(ok), 32'd1);
    check({tag, "_frame"}, 32'(seen), 32'(model_frame(b)));
    tick(20);
    check({tag, "_done"}, 32'(ndone - d0), 32'd1);
    check({tag, "_noerr"}, 32'(nerr - e0), 32'd0);
    check({tag, "_ready"}, 32'({tx_ready, busy}), 32'b10);
  endtask

  initial begin
    int d0, e0, inh, rq, ok, n;
    logic [9:0] seen;
    logic [7:0] b;
    logic [7:0] t2b[3];
    logic       t2p[3];
    t2b = '{8'h01, 8'hFF, 8'h00};
    t2p = '{1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    check("reset_state",
          32'({tx_ready, busy, psClk_oe, psData_oe, done, error, err_code}),
          32'h80);

    // 0xED: phase lengths, exact frame, single done
    d0 = ndone;
    e0 = nerr;
    send(8'hED);
    check("ed_busy", 32'({busy, tx_ready}), 32'b10);
    phases(inh, rq);
    check("ed_inhibit", 32'(inh), 32'd20);
    check("ed_req", 32'(rq), 32'd4);
    dev(0, seen, ok);
    check("ed_frame", 32'(seen), 32'h3ED);
    tick(20);
    check("ed_done", 32'(ndone - d0), 32'd1);
    check("ed_noerr", 32'(nerr - e0), 32'd0);
    check("ed_ready", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 3; i++) begin
      send(t2b[i]);
      phases(inh, rq);
      dev(0, seen, ok);
      check("parity", 32'(seen[8]), 32'(t2p[i]));
      tick(20);
    end

    // no device clock -> timeout 01
    d0 = ndone;
    send(8'hA5);
    phases(inh, rq);
    n = 0;
    while (!error && n < 3000) begin
      tick();
      n++;
    end
    check("start_to_cycles", 32'(n), 32'd2000);
    check("start_to_code", 32'(err_code), 32'd1);
    check("start_to_oe", 32'({psClk_oe, psData_oe}), 32'd0);
    tick();
    check("start_to_pulse", 32'({error, tx_ready}), 32'b01);
    check("start_to_nodone", 32'(ndone - d0), 32'd0);

    // NACK -> 11
    e0 = nerr;
    send(8'($urandom));
    phases(inh, rq);
    dev(1, seen, ok);
    tick(10);
    check("nack_err", 32'(nerr - e0), 32'd1);
    check("nack_code", 32'(err_code), 32'd3);

    // stall after fall 5 -> 10
    e0 = nerr;
    send(8'($urandom));
    phases(inh, rq);
    dev(2, seen, ok);
    n = 0;
    while (nerr == e0 && n < 6000) begin
      tick();
      n++;
    end
    check("stall_err", 32'(nerr - e0), 32'd1);
    check("stall_code", 32'(err_code), 32'd2);

    // request while busy is ignored
    d0 = ndone;
    send(8'hED);
    tick(3);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    tick(2);
    tx_valid = 1'b0;
    phases(inh, rq);
    dev(0, seen, ok);
    check("busy_ign_frame", 32'(seen), 32'(model_frame(8'hED)));
    tick(200);
    check("busy_ign_done", 32'(ndone - d0), 32'd1);
    check("busy_ign_idle", 32'({busy, psClk_oe}), 32'd0);
    check("code_hold", 32'(err_code), 32'd2);
    good_xfer("after_busy", 8'($urandom));

    // reset mid-transfer
    d0 = ndone;
    e0 = nerr;
    send(8'($urandom));
    phases(inh, rq);
    dev(4, seen, ok);
    reset = 1'b1;
    tick();
    check("midrst_state",
          32'({psClk_oe, psData_oe, busy, tx_ready}), 32'b0001);
    reset = 1'b0;
    tick(5);
    check("midrst_pulses", 32'({ndone - d0, nerr - e0}), 32'd0);
    good_xfer("f4", 8'hF4);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      good_xfer("rand", b);
    end

    check("done_err_excl", 32'(nboth), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
